// File: rtl/fractal_scheduler.sv
// Round-robin dispatcher for the Mandelbrot core array with in-order retire into a valid/ready pixel stream.
// Optional macro FRACTAL_SCHED_PERF_EN adds frame-cycle and stall-cycle counters.
module fractal_scheduler #(
  parameter int CORE_COUNT     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16,
  parameter int X_SIZE         = 640,
  parameter int Y_SIZE         = 480,
  parameter logic [DATA_WIDTH-1:0] X_START = DATA_WIDTH'(32'hFE000000),
  parameter logic [DATA_WIDTH-1:0] Y_START = DATA_WIDTH'(32'hFE800000),
  parameter logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(32'h0001999A)
) (
  input  logic                                 out_stream_aclk,
  input  logic                                 periph_resetn,
  input  logic                                 enable_i,
  input  logic [MAX_ITER_WIDTH-1:0]            max_iter_i,
  output logic [CORE_COUNT-1:0]                core_start_o,
  output logic [DATA_WIDTH*CORE_COUNT-1:0]     core_x0_o,
  output logic [DATA_WIDTH*CORE_COUNT-1:0]     core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0]            core_max_iter_o,
  input  logic [CORE_COUNT-1:0]                core_done_i,
  input  logic [MAX_ITER_WIDTH*CORE_COUNT-1:0] core_iter_i,
  output logic                                 pix_valid_o,
  input  logic                                 pix_ready_i,
  output logic [MAX_ITER_WIDTH-1:0]            pix_iter_o,
  output logic                                 pix_sof_o,
  output logic                                 pix_eol_o,
  output logic                                 idle_o
`ifdef FRACTAL_SCHED_PERF_EN
  ,
  output logic [31:0]                          perf_frame_cycles_o,
  output logic [31:0]                          perf_stall_cycles_o
`endif
);

  localparam int PW = $clog2(CORE_COUNT);
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CORE_COUNT - 1);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  logic [PW-1:0]         r_issue_ptr;
  logic [PW-1:0]         r_retire_ptr;
  logic [CORE_COUNT-1:0] r_busy;
  logic [CORE_COUNT-1:0] r_tag_sof;
  logic [CORE_COUNT-1:0] r_tag_eol;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [DATA_WIDTH-1:0] r_xc;
  logic [DATA_WIDTH-1:0] r_yc;
  logic                  w_issue;
  logic                  w_retire;

  assign w_issue = enable_i && !r_busy[r_issue_ptr];
  // A core's done may still be high from its previous result during its start cycle.
  assign w_retire = r_busy[r_retire_ptr] && core_done_i[r_retire_ptr] &&
                    !core_start_o[r_retire_ptr] && (!pix_valid_o || pix_ready_i);
  assign idle_o = (r_busy == '0) && !pix_valid_o;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      r_issue_ptr     <= '0;
      r_retire_ptr    <= '0;
      r_busy          <= '0;
      r_tag_sof       <= '0;
      r_tag_eol       <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_xc            <= X_START;
      r_yc            <= Y_START;
      core_start_o    <= '0;
      core_x0_o       <= '0;
      core_y0_o       <= '0;
      core_max_iter_o <= '0;
      pix_valid_o     <= 1'b0;
      pix_iter_o      <= '0;
      pix_sof_o       <= 1'b0;
      pix_eol_o       <= 1'b0;
    end else begin
      core_max_iter_o <= max_iter_i;
      core_start_o    <= '0;
      if (w_issue) begin
        core_start_o[r_issue_ptr]                         <= 1'b1;
        core_x0_o[r_issue_ptr*DATA_WIDTH +: DATA_WIDTH]   <= r_xc;
        core_y0_o[r_issue_ptr*DATA_WIDTH +: DATA_WIDTH]   <= r_yc;
        r_busy[r_issue_ptr]    <= 1'b1;
        r_tag_sof[r_issue_ptr] <= (r_x == '0) && (r_y == '0);
        r_tag_eol[r_issue_ptr] <= (r_x == X_LAST);
        r_issue_ptr            <= (r_issue_ptr == P_LAST) ? '0 : r_issue_ptr + 1'b1;
        if (r_x != X_LAST) begin
          r_x  <= r_x + 1'b1;
          r_xc <= r_xc + STEP;
        end else begin
          r_x  <= '0;
          r_xc <= X_START;
          if (r_y != Y_LAST) begin
            r_y  <= r_y + 1'b1;
            r_yc <= r_yc + STEP;
          end else begin
            r_y  <= '0;
            r_yc <= Y_START;
          end
        end
      end
      if (w_retire) begin
        pix_valid_o          <= 1'b1;
        pix_iter_o           <= core_iter_i[r_retire_ptr*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
        pix_sof_o            <= r_tag_sof[r_retire_ptr];
        pix_eol_o            <= r_tag_eol[r_retire_ptr];
        r_busy[r_retire_ptr] <= 1'b0;
        r_retire_ptr         <= (r_retire_ptr == P_LAST) ? '0 : r_retire_ptr + 1'b1;
      end else if (pix_valid_o && pix_ready_i) begin
        pix_valid_o <= 1'b0;
      end
    end
  end

`ifdef FRACTAL_SCHED_PERF_EN
  logic [31:0] r_frame_cnt;

  // Frame length is latched on each accepted sof pixel; stall count runs live and clears there.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      r_frame_cnt         <= '0;
      perf_frame_cycles_o <= '0;
      perf_stall_cycles_o <= '0;
    end else if (pix_valid_o && pix_ready_i && pix_sof_o) begin
      perf_frame_cycles_o <= r_frame_cnt + 32'd1;
      r_frame_cnt         <= '0;
      perf_stall_cycles_o <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
      if (pix_valid_o && !pix_ready_i) perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fractal_scheduler.sv
// Directed bench for fractal_scheduler: 3 cores on a 4x2 raster with a behavioural core model.
module tb_fractal_scheduler;
  localparam int NC = 3;
  localparam int DW = 32;
  localparam int MW = 16;

  typedef struct {
    logic [15:0] iter;
    logic        sof;
    logic        eol;
    logic [31:0] x0;
    logic [31:0] y0;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [MW-1:0]     max_iter = '0;
  logic [NC-1:0]     core_start;
  logic [DW*NC-1:0]  core_x0;
  logic [DW*NC-1:0]  core_y0;
  logic [MW-1:0]     core_max_iter;
  logic [NC-1:0]     core_done = '0;
  logic [MW*NC-1:0]  core_iter = '0;
  logic              pix_valid;
  logic              ready = 1'b1;
  logic [MW-1:0]     pix_iter;
  logic              pix_sof;
  logic              pix_eol;
  logic              idle;

  int checks = 0;
  int errors = 0;
  int dly[NC];
  int cnt[NC];
  int start_seq = 0;
  int multi_start = 0;
  logic [31:0] st_x[$];
  logic [31:0] st_y[$];
  logic [15:0] pq_iter[$];
  logic        pq_sof[$];
  logic        pq_eol[$];
  vec_t        tbl[9];

  fractal_scheduler #(.CORE_COUNT(NC), .X_SIZE(4), .Y_SIZE(2)) dut (
    .out_stream_aclk(clk),
    .periph_resetn(rst_n),
    .enable_i(enable),
    .max_iter_i(max_iter),
    .core_start_o(core_start),
    .core_x0_o(core_x0),
    .core_y0_o(core_y0),
    .core_max_iter_o(core_max_iter),
    .core_done_i(core_done),
    .core_iter_i(core_iter),
    .pix_valid_o(pix_valid),
    .pix_ready_i(ready),
    .pix_iter_o(pix_iter),
    .pix_sof_o(pix_sof),
    .pix_eol_o(pix_eol),
    .idle_o(idle)
  );

  always #5 clk = ~clk;

  // Core model and output monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      core_done = '0;
      core_iter = '0;
      start_seq = 0;
      for (int k = 0; k < NC; k++) cnt[k] = 0;
    end else begin
      if ($countones(core_start) > 1) multi_start++;
      for (int k = 0; k < NC; k++) begin
        if (core_start[k]) begin
          st_x.push_back(core_x0[k*DW +: DW]);
          st_y.push_back(core_y0[k*DW +: DW]);
          cnt[k] = dly[k];
          core_done[k] = 1'b0;
          core_iter[k*MW +: MW] = 16'h0100 + start_seq[15:0];
          start_seq++;
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) core_done[k] = 1'b1;
        end
      end
      if (pix_valid && ready) begin
        pq_iter.push_back(pix_iter);
        pq_sof.push_back(pix_sof);
        pq_eol.push_back(pix_eol);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    ready  = 1'b1;
    @(posedge clk); #1;
    st_x.delete(); st_y.delete();
    pq_iter.delete(); pq_sof.delete(); pq_eol.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic set_dly(input int a, input int b, input int c);
    dly[0] = a; dly[1] = b; dly[2] = c;
  endtask

  task automatic issue_n(input int n, input string nm);
    int got = 0;
    int c = 0;
    enable = 1'b1;
    while (got < n && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (core_start != '0) got++;
      if (got == n) enable = 1'b0;
    end
    enable = 1'b0;
    if (got < n) timeout(nm);
  endtask

  task automatic wait_pix(input int n, input string nm);
    int c = 0;
    while (pq_iter.size() < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    if (pq_iter.size() < n) timeout(nm);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (!idle && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    if (!idle) timeout(nm);
  endtask

  task automatic wait_valid(input string nm);
    int c = 0;
    while (!pix_valid && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (!pix_valid) timeout(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int unstable;
    int gaps;
    logic [15:0] h_iter;
    logic        h_sof;
    logic        h_eol;

    tbl[0] = '{16'h0100, 1'b1, 1'b0, 32'hFE000000, 32'hFE800000};
    tbl[1] = '{16'h0101, 1'b0, 1'b0, 32'hFE01999A, 32'hFE800000};
    tbl[2] = '{16'h0102, 1'b0, 1'b0, 32'hFE033334, 32'hFE800000};
    tbl[3] = '{16'h0103, 1'b0, 1'b1, 32'hFE04CCCE, 32'hFE800000};
    tbl[4] = '{16'h0104, 1'b0, 1'b0, 32'hFE000000, 32'hFE81999A};
    tbl[5] = '{16'h0105, 1'b0, 1'b0, 32'hFE01999A, 32'hFE81999A};
    tbl[6] = '{16'h0106, 1'b0, 1'b0, 32'hFE033334, 32'hFE81999A};
    tbl[7] = '{16'h0107, 1'b0, 1'b1, 32'hFE04CCCE, 32'hFE81999A};
    tbl[8] = '{16'h0108, 1'b1, 1'b0, 32'hFE000000, 32'hFE800000};

    // Reset state, with a nonzero max_iter pending.
    set_dly(5, 5, 5);
    max_iter = 16'h0040;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_start", core_start, 0);
    chk("rst_x0", core_x0, 0);
    chk("rst_y0", core_y0, 0);
    chk("rst_maxit", core_max_iter, 0);
    chk("rst_iter", pix_iter, 0);
    chk("rst_tags", {pix_sof, pix_eol}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("maxit_fwd", core_max_iter, 16'h0040);

    // 1: full frame plus the first pixel of the next one.
    ready = 1'b1;
    enable = 1'b1;
    wait_pix(9, "t1_pixels");
    enable = 1'b0;
    wait_idle("t1_idle");
    for (int i = 0; i < 9; i++) begin
      if (i < pq_iter.size()) begin
        chk($sformatf("t1_iter%0d", i), pq_iter[i], tbl[i].iter);
        chk($sformatf("t1_sof%0d", i), pq_sof[i], tbl[i].sof);
        chk($sformatf("t1_eol%0d", i), pq_eol[i], tbl[i].eol);
      end
      if (i < st_x.size()) begin
        chk($sformatf("t1_x0_%0d", i), st_x[i], tbl[i].x0);
        chk($sformatf("t1_y0_%0d", i), st_y[i], tbl[i].y0);
      end
    end

    // 2: core1 finishes first but waits for core0.
    do_reset();
    set_dly(9, 3, 4);
    issue_n(3, "t2_issue");
    begin
      int c = 0;
      while (!core_done[1] && c < 60) begin
        @(posedge clk); #1;
        c++;
      end
      if (!core_done[1]) timeout("t2_done1");
    end
    chk("t2_held", pix_valid, 0);
    wait_pix(3, "t2_pixels");
    wait_idle("t2_idle");
    chk("t2_count", pq_iter.size(), 3);
    for (int i = 0; i < 3 && i < pq_iter.size(); i++)
      chk($sformatf("t2_order%0d", i), pq_iter[i], 16'h0100 + 16'(i));

    // 3: backpressure for 20 cycles.
    do_reset();
    set_dly(2, 2, 2);
    ready = 1'b0;
    enable = 1'b1;
    wait_valid("t3_valid");
    h_iter = pix_iter; h_sof = pix_sof; h_eol = pix_eol;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!pix_valid || pix_iter !== h_iter || pix_sof !== h_sof || pix_eol !== h_eol) unstable++;
    end
    @(negedge clk);
    chk("t3_stable", unstable, 0);
    chk("t3_held_iter", h_iter, 16'h0100);
    chk("t3_held_sof", h_sof, 1);
    chk("t3_starts", st_x.size(), 4);
    @(posedge clk); #1;
    enable = 1'b0;
    ready = 1'b1;
    wait_pix(4, "t3_pixels");
    wait_idle("t3_idle");
    chk("t3_count", pq_iter.size(), 4);
    for (int i = 0; i < 4 && i < pq_iter.size(); i++)
      chk($sformatf("t3_order%0d", i), pq_iter[i], 16'h0100 + 16'(i));

    // 4: pause after two issues, then resume at the saved coordinate.
    do_reset();
    set_dly(3, 3, 3);
    issue_n(2, "t4_issue2");
    wait_idle("t4_idle");
    chk("t4_count", pq_iter.size(), 2);
    chk("t4_idle_flag", idle, 1);
    issue_n(1, "t4_issue3");
    @(negedge clk); #1;
    chk("t4_nstarts", st_x.size(), 3);
    if (st_x.size() >= 3) begin
      chk("t4_resume_x0", st_x[2], 32'hFE033334);
      chk("t4_resume_y0", st_y[2], 32'hFE800000);
    end
    wait_idle("t4_idle2");

    // 5: asynchronous reset with three cores in flight.
    do_reset();
    set_dly(20, 20, 20);
    issue_n(3, "t5_issue");
    @(posedge clk); #1;
    chk("t5_busy", idle, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", pix_valid, 0);
    chk("t5_idle", idle, 1);
    chk("t5_x0", core_x0, 0);
    chk("t5_y0", core_y0, 0);
    chk("t5_maxit", core_max_iter, 0);
    chk("t5_start", core_start, 0);
    repeat (2) @(posedge clk);
    #1;
    st_x.delete(); st_y.delete();
    pq_iter.delete(); pq_sof.delete(); pq_eol.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_dly(2, 2, 2);
    issue_n(1, "t5_issue_post");
    @(negedge clk); #1;
    chk("t5_nstarts", st_x.size(), 1);
    if (st_x.size() >= 1) begin
      chk("t5_post_x0", st_x[0], 32'hFE000000);
      chk("t5_post_y0", st_y[0], 32'hFE800000);
    end
    wait_idle("t5_idle2");

    // 6: fast cores keep the output streaming one pixel per cycle.
    do_reset();
    set_dly(1, 1, 1);
    ready = 1'b1;
    enable = 1'b1;
    wait_valid("t6_valid");
    gaps = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (!pix_valid) gaps++;
    end
    enable = 1'b0;
    chk("t6_gaps", gaps, 0);
    wait_idle("t6_idle");
    chk("t6_min_count", pq_iter.size() >= 16, 1);
    for (int i = 0; i < 16 && i < pq_iter.size(); i++) begin
      chk($sformatf("t6_iter%0d", i), pq_iter[i], 16'h0100 + 16'(i));
      chk($sformatf("t6_sof%0d", i), pq_sof[i], (i % 8) == 0);
      chk($sformatf("t6_eol%0d", i), pq_eol[i], (i % 4) == 3);
    end
    chk("onehot_start", multi_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fractal_scheduler.md
Name: fractal_scheduler

Overview:
Sequences the Mandelbrot core array for the pixel generator. It walks the raster in fixed point and dispatches each pixel's (x0, y0) to the next core in round-robin order. Results are retired in strict issue order, so pixels leave in raster order. The output is a valid/ready pixel stream tagged with sof/eol for the packer.

Parameters:
CORE_COUNT, 9, number of fractal cores scheduled (>=2)
DATA_WIDTH, 32, fixed-point coordinate width (Q8.24)
MAX_ITER_WIDTH, 16, iteration count width
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
X_START, 32'hFE000000, real coordinate of x=0 (-2.0)
Y_START, 32'hFE800000, imaginary coordinate of y=0 (-1.5)
STEP, 32'h0001999A, coordinate increment per pixel/line

Ports:
out_stream_aclk  in  1  clock
periph_resetn  in  1  asynchronous active-low reset
enable_i  in  1  allow new dispatches
max_iter_i  in  MAX_ITER_WIDTH  iteration limit forwarded to cores
core_start_o  out  CORE_COUNT  one-cycle start pulse per core
core_x0_o  out  DATA_WIDTH*CORE_COUNT  per-core x0, slice k = core k
core_y0_o  out  DATA_WIDTH*CORE_COUNT  per-core y0
core_max_iter_o  out  MAX_ITER_WIDTH  registered copy of max_iter_i
core_done_i  in  CORE_COUNT  level; high from completion until next start
core_iter_i  in  MAX_ITER_WIDTH*CORE_COUNT  per-core result, valid while done high
pix_valid_o  out  1  pixel available
pix_ready_i  in  1  consumer accepts pixel
pix_iter_o  out  MAX_ITER_WIDTH  iteration count of pixel
pix_sof_o  out  1  pixel is (0,0)
pix_eol_o  out  1  pixel is x=X_SIZE-1
idle_o  out  1  no core busy and output empty

Behaviour:
- Reset is asynchronous and active-low and applies to all state. On reset: issue_ptr=retire_ptr=0, busy[]=0, x=y=0, xc=X_START, yc=Y_START, core_start_o=0, core_x0_o/core_y0_o=0, core_max_iter_o=0, pix_valid_o=0, pix_iter_o=0, pix_sof_o=0, pix_eol_o=0, idle_o=1.
- Reset mid-frame discards all in-flight pixels. The next frame restarts at (0,0).
- core_max_iter_o <= max_iter_i every cycle.
- Issue: when enable_i && !busy[issue_ptr], pulse core_start_o[issue_ptr] for exactly 1 cycle.
  - Write xc/yc into that core's slice in the same cycle as the pulse. The slice holds until the core is re-issued.
  - Set busy[issue_ptr]. Store tag sof=(x==0&&y==0) and eol=(x==X_SIZE-1) for that core.
  - Advance issue_ptr modulo CORE_COUNT. At most one issue per cycle.
- Coordinate advance on each issue:
  - x<X_SIZE-1: x+1, xc+STEP.
  - Otherwise x=0, xc=X_START, and y advances: y+1, yc+STEP; or, if y==Y_SIZE-1, y=0 and yc=Y_START.
  - Adds are DATA_WIDTH two's complement with wrap and no saturation.
- Retire: when busy[retire_ptr] && core_done_i[retire_ptr] && (!pix_valid_o || pix_ready_i):
  - Load pix_iter_o from that core's iter slice, plus its tags.
  - Assert pix_valid_o, clear busy[retire_ptr], advance retire_ptr.
- Done from a core other than retire_ptr is ignored until its turn; it is not lost because done is a level.
- The earliest a core can retire is 1 cycle after its start pulse. The retired pixel is visible on pix_* the cycle after the retire condition.
- Issue and retire may happen in the same cycle.
  - A core retired in cycle t is re-issuable in cycle t+1 at the earliest. busy is checked on registered state.
- Output: if pix_valid_o && pix_ready_i and there is no retire that cycle, pix_valid_o<=0.
  - pix_* hold stable while valid && !ready.
  - A simultaneous accept and retire is a back-to-back transfer with no bubble.
- enable_i low stops issue only; in-flight pixels still retire. Raising enable_i resumes at the saved coordinate.
- idle_o = (busy==0) && !pix_valid_o.
- Changing max_iter_i mid-frame affects only cores started afterwards.

Optional Feature:
FRACTAL_SCHED_PERF_EN: adds outputs perf_frame_cycles_o[31:0] and perf_stall_cycles_o[31:0].
- Frame counter increments every cycle and latches/clears when a pixel with sof is accepted.
- Stall counter counts cycles with pix_valid_o && !pix_ready_i and clears at the same point.
- Both counters reset to 0.
- Without the macro, neither the ports nor the logic exist.

Test Plan:
1. CORE_COUNT=3, X_SIZE=4, Y_SIZE=2, cores complete in 5 cycles, ready=1 -> 8 pixels in raster order; pixel0 sof=1, pixels 3 and 7 eol=1; 9th pixel sof=1 with core x0=FE000000.
2. Core1 done before core0 (delays 9, 3, 4) -> output order still core0, core1, core2; core1's result is held until core0 retires.
3. pix_ready_i low for 20 cycles -> pix_* stable; no core is re-issued beyond 3 busy; stall counter=20 with the macro.
4. enable_i dropped after 2 issues -> exactly 2 pixels out, idle_o=1; re-enable -> third start carries xc=FE000000+2*1999A.
5. periph_resetn asserted while 3 cores busy -> all outputs at reset values immediately (asynchronously); the first post-reset start carries x0=FE000000, y0=FE800000.
6. Simultaneous accept and retire each cycle -> pix_valid_o stays 1 continuously, one pixel per cycle.
